// File: rtl/edu_pkg.sv
// Shared constants and FSM state encoding for the EDU round-robin scheduler.
package edu_pkg;

  localparam int unsigned DW   = 7;
  localparam int unsigned SYNW = 3;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } edu_state_e;

endpackage

// File: rtl/edu_rr_pick.sv
// Combinational round-robin picker: first eligible requester after rr_ptr_i, wrapping modulo NREQ.
module edu_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [TW-1:0]   rr_ptr_i,
  output logic            grant_valid_o,
  output logic [TW-1:0]   grant_idx_o
);

  int unsigned idx;

  // Scan rr_ptr+1 .. rr_ptr+NREQ so the last winner has the lowest priority.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr_i) + k) % NREQ;
      if (!grant_valid_o && eligible_i[TW'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = TW'(idx);
      end
    end
  end

endmodule

// File: rtl/edu_rr_scheduler.sv
// Shares one Hamming(7,4) EDU among NREQ requesters: round-robin capture, tagged issue,
// tag-routed result slots, saturating corrected-word counter and sticky protocol error.
module edu_rr_scheduler
  import edu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = edu_pkg::DW,
  parameter int unsigned TW   = $clog2(NREQ),
  parameter int unsigned CNTW = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    in_valid,
  output logic [NREQ-1:0]    in_ready,
  input  logic [NREQ*DW-1:0] in_data,
  output logic               edu_req_valid,
  input  logic               edu_req_ready,
  output logic [DW-1:0]      edu_req_data,
  output logic [TW-1:0]      edu_req_tag,
  input  logic               edu_rsp_valid,
  output logic               edu_rsp_ready,
  input  logic [DW-1:0]      edu_rsp_data,
  input  logic [TW-1:0]      edu_rsp_tag,
  input  logic [SYNW-1:0]    edu_rsp_syndrome,
  output logic [NREQ-1:0]    out_valid,
  input  logic [NREQ-1:0]    out_ready,
  output logic [NREQ*DW-1:0] out_data,
  output logic [CNTW-1:0]    corr_cnt,
  output logic               protocol_err
);

  edu_state_e         state_q,     state_d;
  logic [TW-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [NREQ-1:0]    busy_q,      busy_d;
  logic [NREQ-1:0]    in_ready_q,  in_ready_d;
  logic               req_valid_q, req_valid_d;
  logic [DW-1:0]      req_data_q,  req_data_d;
  logic [TW-1:0]      req_tag_q,   req_tag_d;
  logic [NREQ-1:0]    out_valid_q, out_valid_d;
  logic [NREQ*DW-1:0] out_data_q,  out_data_d;
  logic [CNTW-1:0]    corr_cnt_q,  corr_cnt_d;
  logic               perr_q,      perr_d;

  logic [NREQ-1:0]    eligible;
  logic               grant_valid;
  logic [TW-1:0]      grant_idx;
  logic               rsp_tag_busy;
  logic               rsp_slot_full;
  logic               rsp_fire;
  logic               rsp_hit;

  assign eligible = in_valid & ~busy_q;

  edu_rr_pick #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_pick (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Tag lookup; a tag outside 0..NREQ-1 matches no slot and reads as not outstanding.
  always_comb begin
    rsp_tag_busy  = 1'b0;
    rsp_slot_full = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (edu_rsp_tag == TW'(i)) begin
        rsp_tag_busy  = busy_q[i];
        rsp_slot_full = out_valid_q[i];
      end
    end
  end

  assign edu_rsp_ready = ~reset & ~rsp_slot_full;
  assign rsp_fire      = edu_rsp_valid & edu_rsp_ready;
  assign rsp_hit       = rsp_fire & rsp_tag_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= TW'(NREQ - 1);
      busy_q      <= '0;
      in_ready_q  <= '0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      corr_cnt_q  <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      corr_cnt_q  <= corr_cnt_d;
      perr_q      <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    in_ready_d  = '0;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
    req_tag_d   = req_tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    corr_cnt_d  = corr_cnt_q;
    perr_d      = perr_q;

    // Capture / issue FSM
    unique case (state_q)
      ARB: begin
        if (grant_valid) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == TW'(i)) begin
              in_ready_d[i] = 1'b1;
              busy_d[i]     = 1'b1;
              req_data_d    = in_data[i*DW +: DW];
            end
          end
          req_tag_d   = grant_idx;
          rr_ptr_d    = grant_idx;
          req_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (edu_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    // Response routing; a slot being filled cannot also be handshaking out.
    if (rsp_hit) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (edu_rsp_tag == TW'(i)) begin
          out_valid_d[i]           = 1'b1;
          out_data_d[i*DW +: DW]   = edu_rsp_data;
        end
      end
      if ((edu_rsp_syndrome != '0) && (corr_cnt_q != {CNTW{1'b1}})) begin
        corr_cnt_d = corr_cnt_q + CNTW'(1);
      end
    end else if (rsp_fire) begin
      perr_d = 1'b1;
    end

    // Output slot drain frees the requester for arbitration next cycle.
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (out_valid_q[i] && out_ready[i]) begin
        out_valid_d[i] = 1'b0;
        busy_d[i]      = 1'b0;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign edu_req_valid = req_valid_q;
  assign edu_req_data  = req_data_q;
  assign edu_req_tag   = req_tag_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign corr_cnt      = corr_cnt_q;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_edu_rr_scheduler.sv
// Directed bench for edu_rr_scheduler (NREQ=4, CNTW=4 so counter saturation is reachable).
module tb_edu_rr_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 7;
  localparam int unsigned TW   = 2;
  localparam int unsigned CNTW = 4;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    in_valid;
  logic [NREQ-1:0]    in_ready;
  logic [NREQ*DW-1:0] in_data;
  logic               edu_req_valid;
  logic               edu_req_ready;
  logic [DW-1:0]      edu_req_data;
  logic [TW-1:0]      edu_req_tag;
  logic               edu_rsp_valid;
  logic               edu_rsp_ready;
  logic [DW-1:0]      edu_rsp_data;
  logic [TW-1:0]      edu_rsp_tag;
  logic [2:0]         edu_rsp_syndrome;
  logic [NREQ-1:0]    out_valid;
  logic [NREQ-1:0]    out_ready;
  logic [NREQ*DW-1:0] out_data;
  logic [CNTW-1:0]    corr_cnt;
  logic               protocol_err;

  int n_cmp;
  int n_err;
  int exp_cnt;
  logic [DW-1:0] dat [NREQ];

  edu_rr_scheduler #(
    .NREQ (NREQ),
    .DW   (DW),
    .TW   (TW),
    .CNTW (CNTW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .edu_req_valid    (edu_req_valid),
    .edu_req_ready    (edu_req_ready),
    .edu_req_data     (edu_req_data),
    .edu_req_tag      (edu_req_tag),
    .edu_rsp_valid    (edu_rsp_valid),
    .edu_rsp_ready    (edu_rsp_ready),
    .edu_rsp_data     (edu_rsp_data),
    .edu_rsp_tag      (edu_rsp_tag),
    .edu_rsp_syndrome (edu_rsp_syndrome),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .corr_cnt         (corr_cnt),
    .protocol_err     (protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready",  32'(in_ready),      32'd0);
    chk("rst_req_valid", 32'(edu_req_valid), 32'd0);
    chk("rst_req_data",  32'(edu_req_data),  32'd0);
    chk("rst_req_tag",   32'(edu_req_tag),   32'd0);
    chk("rst_out_valid", 32'(out_valid),     32'd0);
    chk("rst_out_data",  32'(out_data),      32'd0);
    chk("rst_corr_cnt",  32'(corr_cnt),      32'd0);
    chk("rst_perr",      32'(protocol_err),  32'd0);
  endtask

  // One capture + issue + immediate EDU response for requester exp.
  task automatic xact(input int exp, input logic [2:0] syn);
    logic [DW-1:0] rsp;
    rsp = dat[exp] ^ 7'h01;
    tick();
    chk("cap_req_valid", 32'(edu_req_valid), 32'd1);
    chk("cap_req_tag",   32'(edu_req_tag),   32'(exp));
    chk("cap_req_data",  32'(edu_req_data),  32'(dat[exp]));
    chk("cap_in_ready",  32'(in_ready),      32'd1 << exp);
    edu_req_ready    = 1'b1;
    edu_rsp_valid    = 1'b1;
    edu_rsp_tag      = TW'(exp);
    edu_rsp_data     = rsp;
    edu_rsp_syndrome = syn;
    tick();
    edu_rsp_valid = 1'b0;
    if ((syn != 3'd0) && (exp_cnt != 15)) exp_cnt++;
    chk("iss_req_idle",  32'(edu_req_valid),            32'd0);
    chk("rsp_out_valid", 32'(out_valid[exp]),           32'd1);
    chk("rsp_out_data",  32'(out_data[exp*DW +: DW]),   32'(rsp));
    chk("rsp_corr_cnt",  32'(corr_cnt),                 32'(exp_cnt));
  endtask

  initial begin
    int seq3 [6];
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    dat[0] = 7'h11; dat[1] = 7'h22; dat[2] = 7'h33; dat[3] = 7'h44;
    seq3[0] = 1; seq3[1] = 2; seq3[2] = 3; seq3[3] = 0; seq3[4] = 2; seq3[5] = 3;

    reset = 1'b1;
    in_valid = '0;
    in_data = '0;
    edu_req_ready = 1'b0;
    edu_rsp_valid = 1'b0;
    edu_rsp_data = '0;
    edu_rsp_tag = '0;
    edu_rsp_syndrome = '0;
    out_ready = '0;
    tick();
    tick();
    chk_reset_state();
    chk("rst_rsp_ready", 32'(edu_rsp_ready), 32'd0);
    reset = 1'b0;

    // Single requester 0, EDU corrects 0000100 -> 0000000
    in_valid = 4'b0001;
    in_data  = {21'd0, 7'b0000100};
    tick();
    chk("t1_in_ready",  32'(in_ready),      32'h1);
    chk("t1_req_valid", 32'(edu_req_valid), 32'd1);
    chk("t1_req_tag",   32'(edu_req_tag),   32'd0);
    chk("t1_req_data",  32'(edu_req_data),  32'b0000100);
    in_valid = '0;
    edu_req_ready = 1'b1;
    tick();
    chk("t1_req_idle",  32'(edu_req_valid), 32'd0);
    chk("t1_in_ready0", 32'(in_ready),      32'd0);
    edu_req_ready = 1'b0;
    edu_rsp_valid = 1'b1;
    edu_rsp_tag = 2'd0;
    edu_rsp_data = 7'b0000000;
    edu_rsp_syndrome = 3'd3;
    chk("t1_rsp_ready", 32'(edu_rsp_ready), 32'd1);
    tick();
    edu_rsp_valid = 1'b0;
    exp_cnt = 1;
    chk("t1_out_valid", 32'(out_valid),     32'h1);
    chk("t1_out_data",  32'(out_data[6:0]), 32'd0);
    chk("t1_corr_cnt",  32'(corr_cnt),      32'd1);
    chk("t1_rsp_full",  32'(edu_rsp_ready), 32'd0);
    out_ready = 4'b0001;
    tick();
    chk("t1_out_drain", 32'(out_valid),     32'd0);

    // All requesters valid, all slots drained: strict rotation 1,2,3,0,...
    in_data   = {dat[3], dat[2], dat[1], dat[0]};
    in_valid  = 4'b1111;
    out_ready = 4'b1111;
    for (int n = 0; n < 8; n++) xact((1 + n) % 4, 3'd0);
    in_valid = '0;
    tick();
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Requester 1 slot not consumed: it is skipped while busy
    in_valid  = 4'b1111;
    out_ready = 4'b1101;
    for (int n = 0; n < 6; n++) begin
      xact(seq3[n], 3'd0);
      chk("t3_slot1_held", 32'(out_valid[1]), 32'd1);
    end
    in_valid  = '0;
    out_ready = 4'b1111;
    tick();
    chk("t3_released", 32'(out_valid), 32'd0);

    // EDU backpressure for 5 cycles: request stable, no new capture
    edu_req_ready = 1'b0;
    in_valid = 4'b0100;
    tick();
    chk("t4_req_valid", 32'(edu_req_valid), 32'd1);
    chk("t4_req_tag",   32'(edu_req_tag),   32'd2);
    in_valid = 4'b1011;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t4_stall_valid", 32'(edu_req_valid), 32'd1);
      chk("t4_stall_tag",   32'(edu_req_tag),   32'd2);
      chk("t4_stall_data",  32'(edu_req_data),  32'(dat[2]));
      chk("t4_stall_rdy",   32'(in_ready),      32'd0);
    end
    edu_req_ready = 1'b1;
    tick();
    in_valid = '0;
    edu_req_ready = 1'b0;
    chk("t4_req_idle", 32'(edu_req_valid), 32'd0);
    edu_rsp_valid = 1'b1;
    edu_rsp_tag = 2'd2;
    edu_rsp_data = dat[2];
    edu_rsp_syndrome = 3'd0;
    tick();
    edu_rsp_valid = 1'b0;
    chk("t4_out_valid", 32'(out_valid), 32'h4);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Response for a tag that is not outstanding
    edu_rsp_valid = 1'b1;
    edu_rsp_tag = 2'd2;
    edu_rsp_data = 7'h55;
    edu_rsp_syndrome = 3'd5;
    chk("t5_rsp_ready", 32'(edu_rsp_ready), 32'd1);
    tick();
    edu_rsp_valid = 1'b0;
    chk("t5_perr",      32'(protocol_err), 32'd1);
    chk("t5_corr_cnt",  32'(corr_cnt),     32'(exp_cnt));
    chk("t5_dropped",   32'(out_valid),    32'd0);
    tick();
    chk("t5_perr_held", 32'(protocol_err), 32'd1);

    // 17 corrected results: 4-bit counter must stop at 15
    in_valid = 4'b0001;
    for (int n = 0; n < 17; n++) begin
      xact(0, 3'd1);
      tick();
    end
    in_valid = '0;
    chk("t6_saturated", 32'(corr_cnt), 32'd15);

    // Reset during ISSUE, then a late response
    edu_req_ready = 1'b0;
    in_valid = 4'b0010;
    tick();
    chk("t7_in_issue", 32'(edu_req_valid), 32'd1);
    reset = 1'b1;
    in_valid = '0;
    tick();
    chk_reset_state();
    chk("t7_rsp_ready_rst", 32'(edu_rsp_ready), 32'd0);
    reset = 1'b0;
    edu_rsp_valid = 1'b1;
    edu_rsp_tag = 2'd1;
    edu_rsp_data = dat[1];
    edu_rsp_syndrome = 3'd2;
    tick();
    edu_rsp_valid = 1'b0;
    chk("t7_late_perr", 32'(protocol_err), 32'd1);
    chk("t7_late_cnt",  32'(corr_cnt),     32'd0);
    in_valid = 4'b1111;
    tick();
    chk("t7_prio_tag",   32'(edu_req_tag), 32'd0);
    chk("t7_prio_ready", 32'(in_ready),    32'h1);
    in_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
